// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation encodings,
// controller state type and a mode classification helper.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_RSVD  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Only shifts and rotates can be repeated as a burst.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) ||
           (mode == MODE_ROTL) || (mode == MODE_ROTR);
  endfunction

endpackage

// File: rtl/shift_ctrl.sv
// Burst controller: decides which operation the datapath applies on each edge
// and tracks the remaining burst length, busy and the done pulse.
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic [2:0]       op_mode,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic [2:0]       run_mode, run_mode_next;
  logic             done_next;

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    run_mode_next  = run_mode;
    done_next      = 1'b0;
    op_mode        = mode;
    case (state)
      IDLE: begin
        if (start && is_shift_mode(mode)) begin
          if (shift_cnt == '0) begin
            // An empty burst leaves q alone but still acknowledges the request.
            op_mode   = MODE_HOLD;
            done_next = 1'b1;
          end else begin
            run_mode_next  = mode;
            remaining_next = shift_cnt - CNT_W'(1);
            if (shift_cnt != CNT_W'(1)) state_next = RUN;
            else                        done_next  = 1'b1;
          end
        end
      end
      RUN: begin
        op_mode        = run_mode;
        remaining_next = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      run_mode  <= MODE_HOLD;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      run_mode  <= run_mode_next;
      busy      <= (state_next == RUN);
      done      <= done_next;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operations and counted bursts of
// shifts/rotates; shift_ctrl selects the operation, this level owns q.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  logic [2:0]       op_mode;
  logic [WIDTH-1:0] q_next;

  shift_ctrl #(
    .CNT_W(CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .start    (start),
    .shift_cnt(shift_cnt),
    .op_mode  (op_mode),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    q_next = q;
    case (op_mode)
      MODE_LOAD:  q_next = load_data;
      MODE_SHL:   q_next = {q[WIDTH-2:0], ser_in_l};
      MODE_SHR:   q_next = {ser_in_r, q[WIDTH-1:1]};
      MODE_ROTL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_CLEAR: q_next = '0;
      default:    q_next = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= q_next;
  end

  assign ser_out_l = q[WIDTH-1];
  assign ser_out_r = q[0];

endmodule
